// File: rtl/syscall_ctrl.sv
// Run/pause/step/halt sequencer driven by syscalls and a debounced-free go button; en is combinational from state.
// No backpressure: go edges outside PAUSE are dropped, syscalls with en=0 are ignored.
`timescale 1ns/1ps
module syscall_ctrl #(
  parameter logic [31:0] HALT_CODE = 32'd10,
  parameter logic [31:0] DISP_CODE = 32'd34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Syscall,
  input  logic [31:0] V0_data,
  input  logic [31:0] A0_data,
  input  logic        go,
  input  logic        step_mode,
  output logic        en,
  output logic        Halted,
  output logic [31:0] Disp_data,
  output logic [31:0] Cycle_count,
  output logic [15:0] Syscall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    STEP  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        go_s1, go_s2, go_s3;
  logic        go_edge;
  logic        exec, exec_halt, exec_disp, exec_pause;
  logic [31:0] disp_q;
  logic [31:0] cyc_q;
  logic [15:0] sys_q;

  // go is asynchronous: two-flop synchronizer, third flop for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go_s1 <= 1'b0;
      go_s2 <= 1'b0;
      go_s3 <= 1'b0;
    end else begin
      go_s1 <= go;
      go_s2 <= go_s1;
      go_s3 <= go_s2;
    end
  end

  assign go_edge    = go_s2 & ~go_s3;
  assign en         = (state_q == RUN) || (state_q == STEP);
  assign exec       = Syscall & en;
  assign exec_halt  = exec && (V0_data == HALT_CODE);
  assign exec_disp  = exec && (V0_data == DISP_CODE) && !exec_halt;
  assign exec_pause = exec && !exec_halt && !exec_disp;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (exec_halt)                    state_d = HALT;
        else if (exec_pause || step_mode) state_d = PAUSE;
        else                              state_d = RUN;
      end
      STEP: begin
        if (exec_halt) state_d = HALT;
        else           state_d = PAUSE;
      end
      PAUSE: begin
        if (go_edge) state_d = step_mode ? STEP : RUN;
      end
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      disp_q  <= 32'd0;
      cyc_q   <= 32'd0;
      sys_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      if (exec_disp)
        disp_q <= A0_data;
      // cycle counter saturates, syscall counter wraps
      if (en && (cyc_q != 32'hFFFF_FFFF))
        cyc_q <= cyc_q + 32'd1;
      if (exec)
        sys_q <= sys_q + 16'd1;
    end
  end

  assign Halted        = (state_q == HALT);
  assign Disp_data     = disp_q;
  assign Cycle_count   = cyc_q;
  assign Syscall_count = sys_q;

endmodule

// File: tb/tb_syscall_ctrl.sv
// Directed, table-driven bench for syscall_ctrl plus hand-written reset, saturation and wrap sequences.
`timescale 1ns/1ps
module tb_syscall_ctrl;

  logic        clk;
  logic        rst;
  logic        Syscall;
  logic [31:0] V0_data;
  logic [31:0] A0_data;
  logic        go;
  logic        step_mode;
  logic        en;
  logic        Halted;
  logic [31:0] Disp_data;
  logic [31:0] Cycle_count;
  logic [15:0] Syscall_count;

  int n_checks = 0;
  int n_fail   = 0;

  syscall_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .Syscall      (Syscall),
    .V0_data      (V0_data),
    .A0_data      (A0_data),
    .go           (go),
    .step_mode    (step_mode),
    .en           (en),
    .Halted       (Halted),
    .Disp_data    (Disp_data),
    .Cycle_count  (Cycle_count),
    .Syscall_count(Syscall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sc;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        step;
    logic        go;
    logic        en;
    logic        halted;
    logic [31:0] disp;
    logic [31:0] cyc;
    logic [15:0] sys;
  } vec_t;

  localparam int NVEC = 28;
  localparam logic [31:0] D1 = 32'h1234_ABCD;
  localparam logic [31:0] D2 = 32'hCAFE_F00D;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic sc, input logic [31:0] v0, input logic [31:0] a0,
                              input logic step, input logic g, input logic e, input logic h,
                              input logic [31:0] d, input logic [31:0] c, input logic [15:0] s);
    vec_t v;
    v.sc = sc; v.v0 = v0; v.a0 = a0; v.step = step; v.go = g;
    v.en = e; v.halted = h; v.disp = d; v.cyc = c; v.sys = s;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e, input logic h, input logic [31:0] d,
                         input logic [31:0] c, input logic [15:0] s);
    chk({tag, " en"},     {31'd0, en},     {31'd0, e});
    chk({tag, " halted"}, {31'd0, Halted}, {31'd0, h});
    chk({tag, " disp"},   Disp_data,       d);
    chk({tag, " cyc"},    Cycle_count,     c);
    chk({tag, " sys"},    {16'd0, Syscall_count}, {16'd0, s});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                sc  v0      a0             st go   en h  disp cyc sys
    vecs[0]  = mk(0, 32'd0,  32'd0,         0, 0,   1, 0, 32'd0, 1, 0);
    vecs[1]  = mk(1, 32'd34, D1,            0, 0,   1, 0, D1, 2, 1);
    vecs[2]  = mk(1, 32'd5,  32'd0,         0, 0,   0, 0, D1, 3, 2);
    vecs[3]  = mk(1, 32'd10, 32'd0,         0, 0,   0, 0, D1, 3, 2);
    vecs[4]  = mk(0, 32'd0,  32'd0,         0, 1,   0, 0, D1, 3, 2);
    vecs[5]  = mk(0, 32'd0,  32'd0,         0, 1,   0, 0, D1, 3, 2);
    vecs[6]  = mk(0, 32'd0,  32'd0,         0, 1,   1, 0, D1, 3, 2);
    vecs[7]  = mk(0, 32'd0,  32'd0,         0, 0,   1, 0, D1, 4, 2);
    vecs[8]  = mk(0, 32'd0,  32'd0,         1, 0,   0, 0, D1, 5, 2);
    vecs[9]  = mk(0, 32'd0,  32'd0,         1, 1,   0, 0, D1, 5, 2);
    vecs[10] = mk(0, 32'd0,  32'd0,         1, 0,   0, 0, D1, 5, 2);
    vecs[11] = mk(0, 32'd0,  32'd0,         1, 0,   1, 0, D1, 5, 2);
    vecs[12] = mk(0, 32'd0,  32'd0,         1, 0,   0, 0, D1, 6, 2);
    vecs[13] = mk(0, 32'd0,  32'd0,         1, 0,   0, 0, D1, 6, 2);
    vecs[14] = mk(0, 32'd0,  32'd0,         1, 1,   0, 0, D1, 6, 2);
    vecs[15] = mk(0, 32'd0,  32'd0,         1, 0,   0, 0, D1, 6, 2);
    vecs[16] = mk(1, 32'd34, D2,            1, 0,   1, 0, D1, 6, 2);
    vecs[17] = mk(1, 32'd34, D2,            1, 0,   0, 0, D2, 7, 3);
    vecs[18] = mk(0, 32'd0,  32'd0,         0, 1,   0, 0, D2, 7, 3);
    vecs[19] = mk(0, 32'd0,  32'd0,         0, 1,   0, 0, D2, 7, 3);
    vecs[20] = mk(0, 32'd0,  32'd0,         0, 1,   1, 0, D2, 7, 3);
    vecs[21] = mk(0, 32'd0,  32'd0,         0, 1,   1, 0, D2, 8, 3);
    vecs[22] = mk(1, 32'd10, 32'd0,         1, 1,   0, 1, D2, 9, 4);
    vecs[23] = mk(0, 32'd0,  32'd0,         0, 0,   0, 1, D2, 9, 4);
    vecs[24] = mk(0, 32'd0,  32'd0,         0, 1,   0, 1, D2, 9, 4);
    vecs[25] = mk(0, 32'd0,  32'd0,         1, 1,   0, 1, D2, 9, 4);
    vecs[26] = mk(0, 32'd0,  32'd0,         0, 1,   0, 1, D2, 9, 4);
    vecs[27] = mk(1, 32'd34, 32'hDEAD_0000, 0, 0,   0, 1, D2, 9, 4);

    rst = 1'b0; Syscall = 1'b0; V0_data = '0; A0_data = '0; go = 1'b0; step_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b1, 1'b0, 32'd0, 32'd0, 16'd0);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      Syscall = vecs[i].sc; V0_data = vecs[i].v0; A0_data = vecs[i].a0;
      step_mode = vecs[i].step; go = vecs[i].go;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].halted, vecs[i].disp,
              vecs[i].cyc, vecs[i].sys);
      @(negedge clk);
    end

    // asynchronous reset between edges while halted
    Syscall = 1'b0; go = 1'b0; step_mode = 1'b1;
    #2 rst = 1'b0;
    #1 chk_all("async_rst_halt", 1'b1, 1'b0, 32'd0, 32'd0, 16'd0);

    // step_mode held through reset release: one RUN cycle, then PAUSE
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all("step_release", 1'b0, 1'b0, 32'd0, 32'd1, 16'd0);

    // reset during a go pulse must not leave a stale edge behind
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    #2 rst = 1'b0;
    #1 chk("go_rst en", {31'd0, en}, 32'd1);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_all("no_stale_go", 1'b0, 1'b0, 32'd0, 32'd1, 16'd0);

    // cycle counter saturation
    @(negedge clk);
    rst = 1'b0; step_mode = 1'b0;
    #1 rst = 1'b1;
    force dut.cyc_q = 32'hFFFF_FFFD;
    #1 release dut.cyc_q;
    @(posedge clk); #1;
    chk("sat step1", Cycle_count, 32'hFFFF_FFFE);
    repeat (4) @(posedge clk);
    #1;
    chk("sat hold", Cycle_count, 32'hFFFF_FFFF);
    chk("sat en", {31'd0, en}, 32'd1);

    // syscall counter wrap with back-to-back display syscalls
    @(negedge clk);
    rst = 1'b0;
    #1 rst = 1'b1;
    Syscall = 1'b1; V0_data = 32'd34; A0_data = 32'h5A5A_0001;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap ffff", {16'd0, Syscall_count}, 32'h0000_FFFF);
    chk("wrap disp", Disp_data, 32'h5A5A_0001);
    chk("wrap cyc", Cycle_count, 32'd65535);
    @(posedge clk); #1;
    chk("wrap zero", {16'd0, Syscall_count}, 32'd0);
    chk("wrap en", {31'd0, en}, 32'd1);
    Syscall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
